// File: rtl/n8_pad_poller.sv
// n8_pad_poller
// Polls 1..4 NES/SNES-style serial game pads that share one latch/pulse pair.
// Each frame latches the pads and shifts NUM_BITS bits out of every pad. It
// then publishes an active-high button vector together with a one-clk valid
// strobe.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   poll_en  1 = poll continuously, 0 = stop once the current frame ends
//   data_in  serial pad data, one line per pad, active-low, asynchronous
//   latch    pad latch (registered)
//   pulse    pad shift clock (registered)
//   buttons  pressed = 1; pad p is [p*NUM_BITS +: NUM_BITS], bit k = k-th bit shifted
//   valid    one-clk strobe, aligned with the new buttons value
//   busy     high while the frame FSM is not idle
//
// Optional feature: define N8_PAD_DEBOUNCE_EN to publish a pad's field only
// when two consecutive raw frames agree.
//
// Handshake: valid is a pure strobe with no ready. Consumers must sample
// buttons in the cycle where valid=1. buttons then holds until the next strobe.

module n8_pad_poller #(
    parameter int CLK_DIV     = 4,
    parameter int NUM_BITS    = 8,
    parameter int NUM_PADS    = 1,
    parameter int LATCH_TICKS = 2,
    parameter int GAP_TICKS   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         poll_en,
    input  logic [NUM_PADS-1:0]          data_in,
    output logic                         latch,
    output logic                         pulse,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         busy
);

    localparam int D_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int K_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int T_MAX = (LATCH_TICKS > GAP_TICKS) ? LATCH_TICKS : GAP_TICKS;
    localparam int T_W   = $clog2(T_MAX + 1);
    localparam int W     = NUM_PADS * NUM_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_READ_LO, S_READ_HI, S_PUBLISH, S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [D_W-1:0]      div_q, div_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [T_W-1:0]      tcnt_q, tcnt_d;
    logic [W-1:0]        shift_q, shift_d;
    logic [W-1:0]        buttons_q, buttons_d;
    logic                valid_q, valid_d;
    logic                latch_q, latch_d;
    logic                pulse_q, pulse_d;
    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic                tick;
`ifdef N8_PAD_DEBOUNCE_EN
    logic [W-1:0]        prev_q, prev_d;
`endif

    assign tick    = (div_q == D_W'(CLK_DIV - 1));
    assign latch   = latch_q;
    assign pulse   = pulse_q;
    assign buttons = buttons_q;
    assign valid   = valid_q;
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        k_d       = k_q;
        tcnt_d    = tcnt_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
`ifdef N8_PAD_DEBOUNCE_EN
        prev_d    = prev_q;
`endif

        // The divider freezes for the single PUBLISH cycle. GAP therefore
        // starts from a fresh count, and that one clk adds to the frame
        // length instead of being absorbed.
        if (state_q != S_PUBLISH) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick && poll_en) begin
                    state_d = S_LATCH;
                    tcnt_d  = '0;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    if (tcnt_q == T_W'(LATCH_TICKS - 1)) begin
                        state_d = S_READ_LO;
                        k_d     = '0;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_READ_LO: begin
                if (tick) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        for (int b = 0; b < NUM_BITS; b++) begin
                            if (k_q == K_W'(b)) begin
                                shift_d[p*NUM_BITS + b] = sync2_q[p];
                            end
                        end
                    end
                    state_d = (k_q == K_W'(NUM_BITS - 1)) ? S_PUBLISH : S_READ_HI;
                end
            end
            S_READ_HI: begin
                if (tick) begin
                    k_d     = k_q + 1'b1;
                    state_d = S_READ_LO;
                end
            end
            S_PUBLISH: begin
                valid_d = 1'b1;
                state_d = S_GAP;
                tcnt_d  = '0;
`ifdef N8_PAD_DEBOUNCE_EN
                for (int p = 0; p < NUM_PADS; p++) begin
                    if (shift_q[p*NUM_BITS +: NUM_BITS] == prev_q[p*NUM_BITS +: NUM_BITS]) begin
                        buttons_d[p*NUM_BITS +: NUM_BITS] = ~shift_q[p*NUM_BITS +: NUM_BITS];
                    end
                end
                prev_d = shift_q;
`else
                buttons_d = ~shift_q;
`endif
            end
            S_GAP: begin
                if (tick) begin
                    if (tcnt_q == T_W'(GAP_TICKS - 1)) begin
                        state_d = poll_en ? S_LATCH : S_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin levels are decoded from the next state. latch and pulse are
        // then registered and track the state exactly, so they can never
        // overlap.
        latch_d = (state_d == S_LATCH);
        pulse_d = (state_d == S_READ_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            k_q       <= '0;
            tcnt_q    <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
`ifdef N8_PAD_DEBOUNCE_EN
            prev_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            k_q       <= k_d;
            tcnt_q    <= tcnt_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            sync1_q   <= data_in;
            sync2_q   <= sync1_q;
`ifdef N8_PAD_DEBOUNCE_EN
            prev_q    <= prev_d;
`endif
        end
    end

endmodule

// File: tb/tb_n8_pad_poller.sv
// tb_n8_pad_poller
// Scoreboard bench for n8_pad_poller.
// Instance A: defaults with two pads (NES timing).
// Instance B: one pad with 16 bits (SNES timing).
// Stimulus pushes the expected buttons value for each frame. The monitor pops
// and compares whenever valid strobes, and also checks latch/pulse widths,
// pulse counts, overlap and the valid period.

module tb_n8_pad_poller;

`ifdef N8_PAD_DEBOUNCE_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- DUT A: 2 pads x 8 bits ----------------
    logic        poll_en_a = 1'b0;
    logic [1:0]  data_a;
    logic        latch_a, pulse_a, valid_a, busy_a;
    logic [15:0] buttons_a;
    logic [7:0]  pad0_a = 8'h00;
    logic [7:0]  pad1_a = 8'h00;
    logic [4:0]  bidx_a = '0;
    logic        pulse_seen_a = 1'b0;

    n8_pad_poller #(.NUM_PADS(2)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .poll_en (poll_en_a),
        .data_in (data_a),
        .latch   (latch_a),
        .pulse   (pulse_a),
        .buttons (buttons_a),
        .valid   (valid_a),
        .busy    (busy_a)
    );

    // ---------------- DUT B: 1 pad x 16 bits ----------------
    logic        poll_en_b = 1'b0;
    logic [0:0]  data_b;
    logic        latch_b, pulse_b, valid_b, busy_b;
    logic [15:0] buttons_b;
    logic [15:0] pad_b = 16'h0000;
    logic [4:0]  bidx_b = '0;
    logic        pulse_seen_b = 1'b0;

    n8_pad_poller #(.NUM_BITS(16), .NUM_PADS(1)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .poll_en (poll_en_b),
        .data_in (data_b),
        .latch   (latch_b),
        .pulse   (pulse_b),
        .buttons (buttons_b),
        .valid   (valid_b),
        .busy    (busy_b)
    );

    // ---------------- pad models (4021-style shift registers) ----------------
    assign data_a = {~pad1_a[bidx_a[2:0]], ~pad0_a[bidx_a[2:0]]};
    assign data_b = ~pad_b[bidx_b[3:0]];

    always @(posedge clk) begin
        if (latch_a) bidx_a <= '0;
        else if (pulse_a && !pulse_seen_a) bidx_a <= bidx_a + 1'b1;
        pulse_seen_a <= pulse_a;
        if (latch_b) bidx_b <= '0;
        else if (pulse_b && !pulse_seen_b) bidx_b <= bidx_b + 1'b1;
        pulse_seen_b <= pulse_b;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    int          latch_run_a, pulse_run_a, pulse_cnt_a, last_valid_a;
    int          latch_run_b, pulse_run_b, pulse_cnt_b;
    logic        pulse_prev_a, pulse_prev_b, overlap_a, overlap_b;
    logic        vchk_a, vchk_b;
    logic [15:0] exp_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            latch_run_a = 0; pulse_run_a = 0; pulse_cnt_a = 0; last_valid_a = -1;
            latch_run_b = 0; pulse_run_b = 0; pulse_cnt_b = 0;
            pulse_prev_a = 1'b0; pulse_prev_b = 1'b0;
            overlap_a = 1'b0; overlap_b = 1'b0;
            vchk_a = 1'b0; vchk_b = 1'b0;
        end else begin
            // ---- instance A ----
            if (vchk_a) begin
                check("valid_a_one_clk", valid_a, 0);
                vchk_a = 1'b0;
            end
            if (latch_a && pulse_a) overlap_a = 1'b1;
            if (latch_a) latch_run_a++;
            else if (latch_run_a != 0) begin
                check("latch_a_width", latch_run_a, 8);
                latch_run_a = 0;
            end
            if (pulse_a) begin
                if (!pulse_prev_a) pulse_cnt_a++;
                pulse_run_a++;
            end else if (pulse_run_a != 0) begin
                check("pulse_a_width", pulse_run_a, 4);
                pulse_run_a = 0;
            end
            pulse_prev_a = pulse_a;
            if (valid_a) begin
                if (exp_a_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_valid_a: valid=1 buttons=%0h, required no strobe", buttons_a);
                end else begin
                    exp_v = exp_a_q.pop_front();
                    check("buttons_a", buttons_a, exp_v);
                end
                check("pulses_per_frame_a", pulse_cnt_a, 7);
                check("latch_pulse_overlap_a", overlap_a, 0);
                if (last_valid_a >= 0) check("valid_period_a", cyc - last_valid_a, 85);
                pulse_cnt_a = 0; overlap_a = 1'b0;
                last_valid_a = cyc; vchk_a = 1'b1;
            end
            if (!poll_en_a) last_valid_a = -1;

            // ---- instance B ----
            if (vchk_b) begin
                check("valid_b_one_clk", valid_b, 0);
                vchk_b = 1'b0;
            end
            if (latch_b && pulse_b) overlap_b = 1'b1;
            if (latch_b) latch_run_b++;
            else if (latch_run_b != 0) begin
                check("latch_b_width", latch_run_b, 8);
                latch_run_b = 0;
            end
            if (pulse_b) begin
                if (!pulse_prev_b) pulse_cnt_b++;
                pulse_run_b++;
            end else if (pulse_run_b != 0) begin
                check("pulse_b_width", pulse_run_b, 4);
                pulse_run_b = 0;
            end
            pulse_prev_b = pulse_b;
            if (valid_b) begin
                if (exp_b_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_valid_b: valid=1 buttons=%0h, required no strobe", buttons_b);
                end else begin
                    exp_v = exp_b_q.pop_front();
                    check("buttons_b", buttons_b, exp_v);
                end
                check("pulses_per_frame_b", pulse_cnt_b, 15);
                check("latch_pulse_overlap_b", overlap_b, 0);
                pulse_cnt_b = 0; overlap_b = 1'b0; vchk_b = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valid_a(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < budget);
        check("valid_a_arrives", valid_a, 1);
        #1;
    endtask

    task automatic wait_valid_b(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_b && n < budget);
        check("valid_b_arrives", valid_b, 1);
        #1;
    endtask

    task automatic wait_pulse_falls_a(input int want, input int budget);
        int   seen = 0;
        int   n    = 0;
        logic prev = pulse_a;
        while (seen < want && n < budget) begin
            @(negedge clk);
            n++;
            if (prev && !pulse_a) seen++;
            prev = pulse_a;
        end
        check("pulse_falls_a", seen, want);
    endtask

    task automatic run_vec_a(input logic [7:0] p1, input logic [7:0] p0, input logic [15:0] e);
        pad1_a = p1;
        pad0_a = p0;
        exp_a_q.push_back(e);
        wait_valid_a(200);
    endtask

    task automatic run_vec_b(input logic [15:0] p, input logic [15:0] e);
        pad_b = p;
        exp_b_q.push_back(e);
        wait_valid_b(300);
    endtask

    // Pressed-button views per frame, with hand-computed published values.
    logic [7:0]  tab_p1 [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'hFF, 8'hFF};
    logic [7:0]  tab_p0 [9] = '{8'h01, 8'h02, 8'h02, 8'h81, 8'h81, 8'h81, 8'h81, 8'h00, 8'h00};
    logic [15:0] tab_nd [9] = '{16'h0001, 16'h0002, 16'h0002, 16'h0081, 16'h0081,
                                16'h5A81, 16'h5A81, 16'hFF00, 16'hFF00};
    logic [15:0] tab_db [9] = '{16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0081,
                                16'h0081, 16'h5A81, 16'h5A81, 16'hFF00};
    logic [15:0] tab_pb [4] = '{16'h0001, 16'h0001, 16'hA5C3, 16'hA5C3};
    logic [15:0] tab_eb_db [4] = '{16'h0000, 16'h0001, 16'h0001, 16'hA5C3};

    // ---------------- stimulus ----------------
    initial begin
        int lc;
        repeat (3) @(negedge clk);
        check("por_latch_a", latch_a, 0);
        check("por_pulse_a", pulse_a, 0);
        check("por_buttons_a", buttons_a, 0);
        check("por_valid_a", valid_a, 0);
        check("por_busy_a", busy_a, 0);
        check("por_buttons_b", buttons_b, 0);
        check("por_busy_b", busy_b, 0);
        rst_n = 1'b1;

        // Continuous polling through a table of frames.
        poll_en_a = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_vec_a(tab_p1[i], tab_p0[i], DB ? tab_db[i] : tab_nd[i]);
        end

        // Asynchronous reset in the middle of bit 3: all outputs drop at once.
        pad1_a = 8'h00;
        pad0_a = 8'h33;
        wait_pulse_falls_a(3, 300);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_latch_a", latch_a, 0);
        check("mid_rst_pulse_a", pulse_a, 0);
        check("mid_rst_buttons_a", buttons_a, 0);
        check("mid_rst_valid_a", valid_a, 0);
        check("mid_rst_busy_a", busy_a, 0);
        pad0_a = 8'h10;
        exp_a_q.push_back(DB ? 16'h0000 : 16'h0010);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Drop poll_en during bit 2: this frame still publishes, then idle.
        wait_pulse_falls_a(2, 300);
        poll_en_a = 1'b0;
        wait_valid_a(200);
        repeat (20) @(negedge clk);
        check("stop_busy_a", busy_a, 0);
        lc = 0;
        repeat (200) begin
            @(negedge clk);
            if (latch_a) lc++;
        end
        check("stop_no_latch_a", lc, 0);
        check("idle_hold_buttons_a", buttons_a, DB ? 16'h0000 : 16'h0010);

        poll_en_a = 1'b1;
        run_vec_a(8'h00, 8'h10, 16'h0010);
        poll_en_a = 1'b0;
        repeat (120) @(negedge clk);

        // SNES-length frames on instance B.
        poll_en_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_vec_b(tab_pb[i], DB ? tab_eb_db[i] : tab_pb[i]);
        end
        poll_en_b = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_busy_b", busy_b, 0);

        check("exp_a_drained", exp_a_q.size(), 0);
        check("exp_b_drained", exp_b_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/n8_pad_poller.md
Name: n8_pad_poller

Overview:
- Parametrised serial game-pad poller for NES-class (8-bit) and SNES-class (16-bit) shift-register controllers, up to 4 pads sharing one latch/pulse pair.
- Fully synchronous: a clock-enable tick generator, a frame FSM and per-pad shift registers.
- Publishes an active-high, per-pad button vector once per frame with a one-cycle valid strobe.
- Sits between the controller connector pins and game/LED logic; replaces the single-pad driver.

Parameters:
- CLK_DIV, 4: clk cycles per tick (one tick = one half bit period); must be >= 4.
- NUM_BITS, 8: bits shifted per pad per frame (8 = NES, 16 = SNES).
- NUM_PADS, 1: number of pads, 1..4; each pad has its own data line.
- LATCH_TICKS, 2: ticks latch is held high; must be >= 1.
- GAP_TICKS, 4: idle ticks between frames; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- poll_en  in  1  1 = poll continuously; 0 = stop after the current frame
- data_in  in  NUM_PADS  serial pad data, active-low, asynchronous to clk
- latch  out  1  pad latch, registered
- pulse  out  1  pad shift clock, registered
- buttons  out  NUM_PADS*NUM_BITS  pressed = 1; field p is [p*NUM_BITS +: NUM_BITS]; bit k is the k-th bit shifted
- valid  out  1  one-clk strobe when buttons is updated
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0): latch=0, pulse=0, buttons=0, valid=0, busy=0, FSM=IDLE, all counters and shift registers 0. Takes effect mid-frame immediately; no partial frame is published.
- Sync: data_in passes through a 2-flop synchroniser per pad before sampling.
- Tick: divider counts 0..CLK_DIV-1; tick=1 in the cycle where the count is CLK_DIV-1. The FSM advances only on tick.
- IDLE: latch=0, pulse=0. On a tick with poll_en=1, go to LATCH.
- LATCH: latch=1 for LATCH_TICKS ticks, then READ_LO with k=0.
- READ_LO: pulse=0 for one tick. On its ending tick, sample the synchronised data_in[p] into shift[p][k].
  - If k = NUM_BITS-1, go to PUBLISH.
  - Otherwise go to READ_HI.
- READ_HI: pulse=1 for one tick, k increments, then READ_LO. This gives NUM_BITS-1 pulses per frame.
- PUBLISH: single clk cycle, not tick-gated. buttons field p <= ~shift[p]; valid=1 for that cycle; go to GAP.
- GAP: latch=0, pulse=0 for GAP_TICKS ticks, then:
  - LATCH if poll_en=1;
  - IDLE otherwise.
- poll_en deasserted mid-frame: the current frame completes and publishes; no new frame starts.
- Frame length = LATCH_TICKS + 2*NUM_BITS - 1 + GAP_TICKS ticks, plus one clk cycle for PUBLISH. With defaults: 21 ticks = 84 clk + 1.
- latch and pulse are never high simultaneously. Both change only on tick boundaries, except at PUBLISH where they are already 0.
- buttons holds its value between valid strobes and while IDLE.
- k counter width: clog2(NUM_BITS). No wrap beyond NUM_BITS-1.

Optional Feature:
- Macro N8_PAD_DEBOUNCE_EN.
- Defined:
  - Each pad keeps the previous raw frame.
  - At PUBLISH, field p updates only if the new raw frame equals the previous raw frame; otherwise field p holds its old value.
  - The previous raw frame is always updated.
  - valid still strobes every frame.
  - Reset clears the previous-frame registers to all-1 (no buttons pressed).
- Undefined: every frame updates buttons directly. No extra registers.

Test Plan:
- Reset mid-READ (assert rst_n=0 at bit 3) -> latch=0, pulse=0, buttons=0, valid=0, busy=0 within the same cycle. No valid on release until the next full frame.
- Defaults, NUM_PADS=2; pad0 presses A and Right (data low at bits 0 and 7), pad1 idle -> after the first frame buttons=16'h0081, valid high for exactly 1 clk. Latch high 8 clk, 7 pulses each 4 clk high.
- Continuous poll_en=1 -> valid strobes exactly every 85 clk. Latch/pulse waveform repeats identically; latch and pulse are never high together.
- NUM_BITS=16, NUM_PADS=1; pad drives 16'hFFFE pattern (only bit 0 low) -> buttons=16'h0001; 15 pulses per frame.
- poll_en dropped during bit 2 -> frame completes, valid once, FSM to IDLE, busy=0; no further latch until poll_en=1.
- N8_PAD_DEBOUNCE_EN; pad0 shows 8'h01, 8'h02, 8'h02 on three successive frames (pressed view) -> buttons after each frame: 8'h00, 8'h00, 8'h02; valid on all three.
